// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-GPR in-flight write counters between decode and writeback.
// Optional writeback lookahead (same-cycle forwarding) enabled by defining SCOREBOARD_BYPASS_EN.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        rs_used,
  input  logic        rt_used,
  output logic        stall,
  output logic [31:0] busy_mask,
  output logic        err
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt      [1:31];
  logic [CNT_W-1:0] cntNext  [1:31];
  logic [CNT_W-1:0] cntView  [0:31];
  logic             issueAcc;
  logic             wbAct;
  logic             sameReg;
  logic             underflow;
  logic             rsStall;
  logic             rtStall;
  logic             bypassRs;
  logic             bypassRt;

  // Register 0 is untracked: expose it as a constant-zero entry so lookups need no special case.
  always_comb begin
    cntView[0] = '0;
    for (int i = 1; i < 32; i++) cntView[i] = cnt[i];
  end

  always_comb begin
    issue_ready = !((issue_rd != 5'd0) && (cntView[issue_rd] == CntMax));
`ifdef SCOREBOARD_BYPASS_EN
    if (wb_valid && (wb_rd == issue_rd)) issue_ready = 1'b1;
`endif
  end

  assign issueAcc  = issue_valid && issue_ready && (issue_rd != 5'd0);
  assign wbAct     = wb_valid && (wb_rd != 5'd0);
  assign sameReg   = issueAcc && wbAct && (issue_rd == wb_rd);
  assign underflow = wbAct && !sameReg && (cntView[wb_rd] == '0);

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      cntNext[i] = cnt[i];
      if (issueAcc && (issue_rd == 5'(i)) && !sameReg)
        cntNext[i] = cnt[i] + CntOne;
      else if (wbAct && (wb_rd == 5'(i)) && !sameReg && (cnt[i] != '0))
        cntNext[i] = cnt[i] - CntOne;
    end
  end

`ifdef SCOREBOARD_BYPASS_EN
  // The register file forwards a retiring write, so its last reservation need not stall.
  assign bypassRs = wb_valid && (wb_rd == rs_addr) && (cntView[rs_addr] == CntOne);
  assign bypassRt = wb_valid && (wb_rd == rt_addr) && (cntView[rt_addr] == CntOne);
`else
  assign bypassRs = 1'b0;
  assign bypassRt = 1'b0;
`endif

  assign rsStall = rs_used && (rs_addr != 5'd0) && (cntView[rs_addr] != '0) && !bypassRs;
  assign rtStall = rt_used && (rt_addr != 5'd0) && (cntView[rt_addr] != '0) && !bypassRt;
  assign stall   = rsStall || rtStall;

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < 32; i++) busy_mask[i] = (cnt[i] != '0);
  end

  // NOTE: the counter array is reset explicitly because reset and flush must drop every
  // reservation; a plain storage array would normally be left unreset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) cnt[i] <= '0;
      err <= 1'b0;
    end else if (flush) begin
      for (int i = 1; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) cnt[i] <= cntNext[i];
      if (underflow) err <= 1'b1;
    end
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks in-flight register writes between decode and writeback. Each issued instruction that writes a GPR reserves its destination number, normally the decoder's selected destination, including 31 for link instructions. Writeback releases the reservation. Decode queries two source registers and is stalled while either source has an outstanding write. The block sits beside decode and consumes the destination-register stream at its far (writeback) end.

## Interface
- CNT_W, default 2: width of the per-register in-flight counter. Maximum in-flight writes per register is 2^CNT_W − 1.

Ports:
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; equal to `RESETABLE clears all state
- issue_valid  in  1  instruction leaving decode that writes a GPR
- issue_rd  in  5  destination register of that instruction
- issue_ready  out  1  reservation accepted this cycle
- wb_valid  in  1  writeback retiring a GPR write
- wb_rd  in  5  register being written back
- flush  in  1  pipeline flush (exception/eret); drops all reservations
- rs_addr  in  5  decode source 1
- rt_addr  in  5  decode source 2
- rs_used  in  1  source 1 is read by the instruction
- rt_used  in  1  source 2 is read by the instruction
- stall  out  1  decode must hold
- busy_mask  out  32  bit i set when cnt[i] != 0
- err  out  1  sticky underflow flag

## Operation
- State consists of 31 counters cnt[1..31], each CNT_W bits wide, plus the err flag.
- Register 0 is never tracked:
  - cnt[0] reads as 0.
  - busy_mask[0] = 0.
  - An issue or writeback to register 0 has no effect.
  - issue_ready = 1 when issue_rd = 0.
- issue_ready = 0 only when issue_rd != 0 and cnt[issue_rd] is at its maximum. issue_valid with issue_ready = 0 is ignored, and decode must hold the instruction.
- Issue increments cnt[issue_rd] when issue_valid & issue_ready.
- Writeback decrements cnt[wb_rd] when wb_valid.
- Writeback to a counter already at 0 is an underflow:
  - The counter stays 0.
  - err is set and holds until reset.
- An accepted issue and a writeback to the same register in the same cycle leave the counter unchanged. No err is raised in that case, even if the counter is 0.
- When issue and writeback target different registers in the same cycle, both updates apply.
- flush clears every counter to 0. It takes priority over issue and writeback in the same cycle. err is unaffected by flush.
- reset takes priority over flush and clears all counters and err.
- stall = (rs_used & rs_addr != 0 & cnt[rs_addr] != 0) | (rt_used & rt_addr != 0 & cnt[rt_addr] != 0).
- stall is evaluated against the registered counters only. An issue in the current cycle affects stall from the next cycle.
- The block does not gate its own issue on stall. Decode combines stall and issue_ready.

## Timing
- Counters, err and busy_mask change only at the rising edge of clock. busy_mask is decoded from registered counters, so it has no combinational path from inputs.
- Latency of issue → busy_mask/stall visibility is 1 cycle.
- Latency of writeback → release is 1 cycle without the bypass feature and 0 cycles with it.
- stall and issue_ready are combinational from registered state and the current-cycle inputs.
- Reset values: every cnt = 0, busy_mask = 0, err = 0, stall = 0, issue_ready = 1.
- Reset asserted with operations in flight: all reservations are dropped on the reset edge. Issue and writeback in that cycle are discarded.

## Configuration
- SCOREBOARD_BYPASS_EN, when defined:
  - A source term does not stall when wb_valid & wb_rd equals that source & cnt[source] = 1, because the register file forwards the writeback value in that cycle.
  - Saturation also accepts an issue to a full counter when wb_valid & wb_rd = issue_rd in the same cycle. The net counter is unchanged.
- When undefined, stall and issue_ready depend only on registered counters plus issue_rd, with no writeback lookahead.

## Test plan
- Reset, then issue rd=31; the next cycle query rs=31 with rs_used=1 → stall=1 and busy_mask=0x8000_0000. Writeback rd=31 → the cycle after, stall=0 and busy_mask=0.
- Issue rd=5 three times with CNT_W=2 → cnt[5]=3 and issue_ready=0 for rd=5. A fourth issue is ignored. Three writebacks are required before stall drops for rt=5.
- In the same cycle, issue rd=7 and writeback rd=7 with cnt[7]=1 → cnt[7] stays 1 and err=0. Then issue rd=8 and writeback rd=7 → cnt[7]=0 and cnt[8]=1.
- Writeback rd=9 with cnt[9]=0 → err=1 and stays 1 through a flush. Issue or writeback to rd=0 → busy_mask unchanged and err unchanged.
- Reserve rd=3 and rd=4, then assert flush together with issue rd=6 → busy_mask=0 next cycle. Assert reset in a later cycle with an issue pending → busy_mask=0 and err=0.
- Set cnt[10]=1, then wb_valid rd=10 with rs=10 queried: stall=0 with SCOREBOARD_BYPASS_EN and stall=1 without it.
